// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch stage of the single-cycle core.
//   NOP_INSTR        : canonical addi x0,x0,0 presented when no instruction is valid
//   RESET_PC_DEFAULT : default PC loaded on reset
//   fetch_state_t    : fetch FSM encoding
//   addr_misaligned  : word-alignment check on the two address LSBs
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_REQ   = 3'd0,
    ST_WAIT  = 3'd1,
    ST_VALID = 3'd2,
    ST_DROP  = 3'd3,
    ST_HALT  = 3'd4
  } fetch_state_t;

  function automatic logic addr_misaligned(input logic [1:0] i_lsb);
    return (i_lsb != 2'b00);
  endfunction

endpackage

// File: rtl/fetch_unit_sva.sv
// Protocol checker for fetch_unit's instruction-memory interface.
//   i_state      : fetch FSM state of the observed fetch_unit
//   imem_*       : the memory handshake as seen on the fetch_unit ports
//   flush_i      : redirect, which is allowed to move a pending request address
module fetch_unit_sva
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic            clk,
  input logic            rst_n,
  input fetch_state_t    i_state,
  input logic            imem_req,
  input logic            imem_gnt,
  input logic            imem_rvalid,
  input logic            flush_i,
  input logic [XLEN-1:0] imem_addr
);

  // A response may only arrive while the fetch unit still owes one
  a_rvalid_owed : assert property (@(posedge clk) disable iff (!rst_n)
    imem_rvalid |-> (i_state == ST_WAIT || i_state == ST_DROP));

  // An ungranted request keeps its address unless a redirect moves it
  a_addr_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (imem_req && !imem_gnt && !flush_i) |=> $stable(imem_addr));

endmodule

// File: rtl/pc_next_sel.sv
// Combinational next-PC selection for the fetch stage.
//   i_pc          : PC of the instruction being retired
//   i_pc_src      : taken jump/branch
//   i_jalr        : register-based target (uses i_alu_result with bit 0 cleared)
//   i_pc_target   : pc + imm target for branches and jal
//   i_alu_result  : rs1 + imm target for jalr
//   o_pc_next     : selected next PC
//   o_pc_plus4    : i_pc + 4 (wraps modulo 2^XLEN)
//   o_misaligned  : o_pc_next is not word aligned
module pc_next_sel
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_pc_src,
  input  logic            i_jalr,
  input  logic [XLEN-1:0] i_pc_target,
  input  logic [XLEN-1:0] i_alu_result,
  output logic [XLEN-1:0] o_pc_next,
  output logic [XLEN-1:0] o_pc_plus4,
  output logic            o_misaligned
);

  logic [XLEN-1:0] w_pc_next;
  logic [XLEN-1:0] w_pc_plus4;
  // jalr clears bit 0 of the target, so the LSB of the ALU result never matters
  logic            w_unused_alu_lsb;

  assign w_unused_alu_lsb = i_alu_result[0];

  // Next-PC mux: sequential, pc-relative or register-based target
  always_comb begin
    w_pc_plus4 = i_pc + XLEN'(3'd4);
    if (!i_pc_src) begin
      w_pc_next = w_pc_plus4;
    end else if (i_jalr) begin
      w_pc_next = {i_alu_result[XLEN-1:1], 1'b0};
    end else begin
      w_pc_next = i_pc_target;
    end
  end

  assign o_pc_next    = w_pc_next;
  assign o_pc_plus4   = w_pc_plus4;
  assign o_misaligned = addr_misaligned(w_pc_next[1:0]);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, fetches from a req/gnt/rvalid memory,
// presents one instruction until it retires and then moves to the next PC.
//   clk, rst_n               : clock, asynchronous active-low reset
//   imem_req/addr/gnt        : request channel, request held until granted
//   imem_rvalid/rdata/err    : in-order response channel, one per grant
//   instr_o/instr_valid      : instruction to control_path (NOP when not valid)
//   instr_ready              : valid & ready retires the instruction
//   pc_o/pc_plus4_o          : PC of instr_o and its link value
//   pc_src/jalr/pc_target/alu_result : next-PC decision from the core
//   flush_i/flush_pc         : redirect, abandons the current instruction
//   fetch_err                : sticky bus error / misaligned target, core halts
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_err,
  output logic [31:0]     instr_o,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  input  logic            pc_src,
  input  logic            jalr,
  input  logic [XLEN-1:0] pc_target,
  input  logic [XLEN-1:0] alu_result,
  input  logic            flush_i,
  input  logic [XLEN-1:0] flush_pc,
  output logic            fetch_err
);

  fetch_state_t    r_state;
  fetch_state_t    w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_nxt;
  logic [31:0]     r_instr;
  logic [31:0]     w_instr_nxt;
  logic            r_valid;
  logic            w_valid_nxt;
  logic            r_req;
  logic            w_req_nxt;
  logic            r_err;
  logic            w_err_nxt;

  logic [XLEN-1:0] w_pc_next;
  logic [XLEN-1:0] w_pc_plus4;
  logic            w_next_misaligned;
  logic            w_flush_bad;

  pc_next_sel #(
    .XLEN (XLEN)
  ) u_pc_next_sel (
    .i_pc         (r_pc),
    .i_pc_src     (pc_src),
    .i_jalr       (jalr),
    .i_pc_target  (pc_target),
    .i_alu_result (alu_result),
    .o_pc_next    (w_pc_next),
    .o_pc_plus4   (w_pc_plus4),
    .o_misaligned (w_next_misaligned)
  );

  assign w_flush_bad = addr_misaligned(flush_pc[1:0]);

  // State, PC, instruction and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_REQ;
      r_pc    <= RESET_PC;
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
      r_req   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_instr <= w_instr_nxt;
      r_valid <= w_valid_nxt;
      r_req   <= w_req_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Next-state, next-PC and captured-instruction logic
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_instr_nxt = r_instr;

    case (r_state)
      ST_REQ: begin
        // r_req is low for the first cycle after reset, so a grant there
        // cannot belong to this request.
        if (flush_i) begin
          w_pc_nxt = flush_pc;
          if (w_flush_bad) begin
            w_state_nxt = ST_HALT;
          end else if (r_req && imem_gnt) begin
            w_state_nxt = ST_DROP;
          end else begin
            w_state_nxt = ST_REQ;
          end
        end else if (r_req && imem_gnt) begin
          w_state_nxt = ST_WAIT;
        end else begin
          w_state_nxt = ST_REQ;
        end
      end

      ST_WAIT: begin
        if (flush_i) begin
          w_pc_nxt = flush_pc;
          if (w_flush_bad) begin
            w_state_nxt = ST_HALT;
          end else if (imem_rvalid) begin
            w_state_nxt = ST_REQ;
          end else begin
            w_state_nxt = ST_DROP;
          end
        end else if (imem_rvalid) begin
          if (imem_err) begin
            w_state_nxt = ST_HALT;
          end else begin
            w_instr_nxt = imem_rdata;
            w_state_nxt = ST_VALID;
          end
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end

      ST_DROP: begin
        // The owed response is consumed and thrown away, error included
        if (flush_i) begin
          w_pc_nxt = flush_pc;
        end else begin
          w_pc_nxt = r_pc;
        end
        if (flush_i && w_flush_bad) begin
          w_state_nxt = ST_HALT;
        end else if (imem_rvalid) begin
          w_state_nxt = ST_REQ;
        end else begin
          w_state_nxt = ST_DROP;
        end
      end

      ST_VALID: begin
        // A redirect wins over a retire in the same cycle
        if (flush_i) begin
          w_pc_nxt    = flush_pc;
          w_state_nxt = w_flush_bad ? ST_HALT : ST_REQ;
        end else if (instr_ready) begin
          w_pc_nxt    = w_pc_next;
          w_state_nxt = w_next_misaligned ? ST_HALT : ST_REQ;
        end else begin
          w_state_nxt = ST_VALID;
        end
      end

      ST_HALT: begin
        w_state_nxt = ST_HALT;
      end

      default: begin
        w_state_nxt = ST_HALT;
      end
    endcase

    // Outputs are decoded from the next state so they come straight off flops
    if (w_state_nxt == ST_VALID) begin
      w_valid_nxt = 1'b1;
    end else begin
      w_valid_nxt = 1'b0;
      w_instr_nxt = NOP_INSTR;
    end
    w_req_nxt = (w_state_nxt == ST_REQ);
    w_err_nxt = r_err | (w_state_nxt == ST_HALT);
  end

  assign imem_req    = r_req;
  assign imem_addr   = r_pc;
  assign instr_o     = r_instr;
  assign instr_valid = r_valid;
  assign pc_o        = r_pc;
  assign pc_plus4_o  = w_pc_plus4;
  assign fetch_err   = r_err;

endmodule
